// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one outstanding req/gnt/rvalid transaction with byte-lane steering.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned accesses into memory-free misalign responses.
module lsu_mem_port #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic [4:0]        rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              misalign_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [DWIDTH-1:0] resp_data_q, resp_data_d;
    logic              misalign_q, misalign_d;

    logic [1:0]        size;
    logic [1:0]        a_lo;
    logic [1:0]        off_al;
    logic              is_mem;
    logic              mis_trap;
    logic [3:0]        be_acc;
    logic [DWIDTH-1:0] wdata_acc;

    function automatic logic [DWIDTH-1:0] load_ext(input logic [DWIDTH-1:0] w,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'h0, b};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign size   = funct3_i[1:0];
    assign a_lo   = addr_i[1:0];
    assign is_mem = memren_i | memwren_i;

    // Natural alignment of the lane offset; only matters when misaligned accesses proceed.
    assign off_al = size[1] ? 2'b00 : (size[0] ? {a_lo[1], 1'b0} : a_lo);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_trap = is_mem && ((size == 2'b01 && a_lo[0]) || (size[1] && a_lo != 2'b00));
`else
    assign mis_trap = 1'b0;
`endif

    always_comb begin
        be_acc    = 4'b1111;
        wdata_acc = wdata_i;
        case (size)
            2'b00: begin
                be_acc    = 4'b0001 << off_al;
                wdata_acc = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_acc    = 4'b0011 << off_al;
                wdata_acc = {2{wdata_i[15:0]}};
            end
            default: begin
                be_acc    = 4'b1111;
                wdata_acc = wdata_i;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        resp_data_d = resp_data_q;
        misalign_d  = misalign_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d        = memwren_i;
                    addr_d      = {addr_i[AWIDTH-1:2], 2'b00};
                    wdata_d     = wdata_acc;
                    be_d        = be_acc;
                    funct3_d    = funct3_i;
                    off_d       = off_al;
                    rd_d        = rd_i;
                    resp_data_d = '0;
                    misalign_d  = mis_trap;
                    state_d     = (is_mem && !mis_trap) ? REQ : RESP;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (we_q) begin
                        state_d = RESP;
                    end else if (mem_rvalid_i) begin
                        resp_data_d = load_ext(mem_rdata_i, funct3_q, off_q);
                        state_d     = RESP;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    resp_data_d = load_ext(mem_rdata_i, funct3_q, off_q);
                    state_d     = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            resp_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            resp_data_q <= resp_data_d;
            misalign_q  <= misalign_d;
        end
    end

    // Memory-side fields are gated so the port idles at zero outside REQ.
    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = mem_req_o & we_q;
    assign mem_addr_o   = mem_req_o ? addr_q : '0;
    assign mem_wdata_o  = mem_req_o ? wdata_q : '0;
    assign mem_be_o     = mem_req_o ? be_q : 4'b0000;
    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = resp_data_q;
    assign resp_rd_o    = rd_q;
    assign misalign_o   = resp_valid_o & misalign_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: vector table with a response scoreboard plus reset corner case.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        memren_i;
    logic        memwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        misalign_o;
    logic        busy_o;

    always #5 clk = ~clk;

    lsu_mem_port #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .memren_i(memren_i), .memwren_i(memwren_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o),
        .misalign_o(misalign_o), .busy_o(busy_o)
    );

    typedef struct {
        string       name;
        bit          ren;
        bit          wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gd;
        int          rvd;
        bit          exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        bit          exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        bit          mis;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input bit ren, input bit wen, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                                input logic [31:0] rdata, input int gd, input int rvd, input bit exp_req,
                                input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                                input bit exp_mis);
        vec_t v;
        v.name = nm; v.ren = ren; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.rdata = rdata; v.gd = gd; v.rvd = rvd; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_data = exp_data; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   k;
        int   rc;
        int   gk;
        int   w;
        bit   done;
        bit   is_load;
        is_load = v.ren && !v.wen;
        @(negedge clk);
        w = 0;
        while (!req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({v.name, " ready"}, {31'd0, req_ready_o}, 32'd1);
        memren_i = v.ren; memwren_i = v.wen; funct3_i = v.f3; addr_i = v.addr;
        wdata_i = v.wdata; rd_i = v.rd; req_valid_i = 1'b1;
        e.data = v.exp_data; e.rd = v.rd; e.mis = v.exp_mis;
        if (!v.exp_req) e.lat = 1;
        else if (v.wen) e.lat = v.gd + 2;
        else e.lat = v.gd + v.rvd + 2;
        sb.push_back(e);
        @(negedge clk);
        req_valid_i = 1'b0;
        k = 1; rc = 0; gk = -1; done = 1'b0;
        while (!done && k <= 20) begin
            if (mem_req_o) begin
                chk({v.name, " req_expected"}, {31'd0, mem_req_o}, {31'd0, v.exp_req});
                chk({v.name, " addr"}, mem_addr_o, v.exp_addr);
                chk({v.name, " be"}, {28'd0, mem_be_o}, {28'd0, v.exp_be});
                chk({v.name, " we"}, {31'd0, mem_we_o}, {31'd0, v.wen});
                if (v.wen) chk({v.name, " wdata"}, mem_wdata_o, v.exp_wdata);
            end
            if (resp_valid_o) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    chk({v.name, " sb_empty"}, 32'd0, 32'd1);
                end else begin
                    got = sb.pop_front();
                    chk({v.name, " resp_data"}, resp_data_o, got.data);
                    chk({v.name, " resp_rd"}, {27'd0, resp_rd_o}, {27'd0, got.rd});
                    chk({v.name, " misalign"}, {31'd0, misalign_o}, {31'd0, got.mis});
                    chk({v.name, " latency"}, k, got.lat);
                end
            end
            mem_gnt_i = mem_req_o && (rc == v.gd);
            if (mem_gnt_i) gk = k;
            mem_rvalid_i = is_load && (gk >= 0) && (k == gk + v.rvd);
            mem_rdata_i  = mem_rvalid_i ? v.rdata : 32'h5A5A5A5A;
            if (mem_req_o) rc++;
            if (!done) begin
                @(negedge clk);
                k++;
            end
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        if (!done) begin
            chk({v.name, " resp_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        if (!v.exp_req) chk({v.name, " no_mem_req"}, rc, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        funct3_i = 3'b000; addr_i = '0; wdata_i = '0; rd_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        vecs.push_back(mk("lw",      1, 0, 3'b010, 32'h100, 32'h0,        5'd5, 32'hDEADBEEF, 0, 1, 1, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk("lb",      1, 0, 3'b000, 32'h103, 32'h0,        5'd7, 32'h80112233, 0, 1, 1, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu",     1, 0, 3'b100, 32'h103, 32'h0,        5'd8, 32'h80112233, 0, 1, 1, 32'h100, 4'b1000, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk("lh",      1, 0, 3'b001, 32'h102, 32'h0,        5'd9, 32'h80112233, 0, 1, 1, 32'h100, 4'b1100, 32'h0,        32'hFFFF8011, 0));
        vecs.push_back(mk("lhu_same",1, 0, 3'b101, 32'h100, 32'h0,        5'd10, 32'h80112233, 0, 0, 1, 32'h100, 4'b0011, 32'h0,       32'h00002233, 0));
        vecs.push_back(mk("sb_stall",0, 1, 3'b000, 32'h201, 32'h000000A5, 5'd3, 32'h0,        3, 0, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0,        0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk("sh_mis",  0, 1, 3'b001, 32'h0A1, 32'h1234ABCD, 5'd4, 32'h0,        0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk("lw_mis",  1, 0, 3'b010, 32'h102, 32'h0,        5'd11, 32'hCAFEF00D, 0, 1, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1));
`else
        vecs.push_back(mk("sh_mis",  0, 1, 3'b001, 32'h0A1, 32'h1234ABCD, 5'd4, 32'h0,        0, 0, 1, 32'h0A0, 4'b0011, 32'hABCDABCD, 32'h0,        0));
        vecs.push_back(mk("lw_mis",  1, 0, 3'b010, 32'h102, 32'h0,        5'd11, 32'hCAFEF00D, 0, 1, 1, 32'h100, 4'b1111, 32'h0,       32'hCAFEF00D, 0));
`endif
        vecs.push_back(mk("sw_both", 1, 1, 3'b010, 32'h30C, 32'h12345678, 5'd12, 32'h0,       0, 0, 1, 32'h30C, 4'b1111, 32'h12345678, 32'h0,        0));
        vecs.push_back(mk("noop",    0, 0, 3'b010, 32'h400, 32'h0,        5'd13, 32'h0,       0, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lb_slow", 1, 0, 3'b000, 32'h101, 32'h0,        5'd14, 32'h00007F00, 2, 2, 1, 32'h100, 4'b0010, 32'h0,       32'h0000007F, 0));
        vecs.push_back(mk("f3_011",  1, 0, 3'b011, 32'h104, 32'h0,        5'd15, 32'h11223344, 0, 1, 1, 32'h104, 4'b1111, 32'h0,       32'h11223344, 0));

        repeat (2) @(negedge clk);
        chk("rst ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst resp_data", resp_data_o, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while a load waits for read data; the late rvalid must be ignored.
        @(negedge clk);
        memren_i = 1'b1; memwren_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h40; rd_i = 5'd4;
        req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("rstmid mem_req", {31'd0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("rstmid busy_wait", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid ready", {31'd0, req_ready_o}, 32'd1);
        chk("rstmid busy", {31'd0, busy_o}, 32'd0);
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBADBAD00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            chk("rstmid no_resp", {31'd0, resp_valid_o}, 32'd0);
            chk("rstmid idle", {31'd0, req_ready_o}, 32'd1);
        end
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
